// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
// alu_mdu: RV integer ALU/compare plus M-extension mul/div behind valid/ready.
// Rev 1.0
// ============================================================================
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            cond,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_LT     = 5'd8;
    localparam logic [4:0] OP_LTU    = 5'd9;
    localparam logic [4:0] OP_EQ     = 5'd10;
    localparam logic [4:0] OP_NE     = 5'd11;
    localparam logic [4:0] OP_GE     = 5'd12;
    localparam logic [4:0] OP_GEU    = 5'd13;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [4:0]          r_op;
    logic [SHW-1:0]      r_cnt;
    logic [XLEN-1:0]     r_ma;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_rem;
    logic                r_neg;

    assign busy      = (r_state == S_CALC);
    assign out_valid = (r_state == S_DONE);
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);

    logic w_accept;
    assign w_accept = in_valid && in_ready;

    // Single-cycle ALU and compare path
    logic [XLEN-1:0] w_alu_res;
    logic            w_alu_cond;
    always_comb begin
        w_alu_res  = '0;
        w_alu_cond = 1'b0;
        case (op)
            OP_ADD: w_alu_res = a + b;
            OP_SUB: w_alu_res = a - b;
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_SLL: w_alu_res = a << b[SHW-1:0];
            OP_SRL: w_alu_res = a >> b[SHW-1:0];
            OP_SRA: w_alu_res = $signed(a) >>> b[SHW-1:0];
            OP_LT:  w_alu_cond = ($signed(a) < $signed(b));
            OP_LTU: w_alu_cond = (a < b);
            OP_EQ:  w_alu_cond = (a == b);
            OP_NE:  w_alu_cond = (a != b);
            OP_GE:  w_alu_cond = ($signed(a) >= $signed(b));
            OP_GEU: w_alu_cond = (a >= b);
            default: begin
                w_alu_res  = '0;
                w_alu_cond = 1'b0;
            end
        endcase
        if (op[4:3] == 2'b01) begin
            w_alu_res = {{(XLEN-1){1'b0}}, w_alu_cond};
        end
    end

    // Operand decode for the iterative unit, evaluated on the accept cycle
    logic            w_is_mul, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_div_zero, w_div_ovf, w_iter, w_neg;
    logic [XLEN-1:0] w_ma, w_mb, w_quick_res;
    logic            w_quick_cond;

    assign w_is_mul   = (op[4:2] == 3'b100);
    assign w_is_div   = (op[4:2] == 3'b101);
    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_sa       = w_a_signed && a[XLEN-1];
    assign w_sb       = w_b_signed && b[XLEN-1];
    assign w_ma       = w_sa ? -a : a;
    assign w_mb       = w_sb ? -b : b;
    assign w_div_zero = (b == '0);
    assign w_div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_iter     = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);
    // Remainder takes the dividend's sign; products and quotients take the xor.
    assign w_neg      = ((op == OP_REM) || (op == OP_REMU)) ? w_sa : (w_sa ^ w_sb);

    always_comb begin
        w_quick_res  = w_alu_res;
        w_quick_cond = w_alu_cond;
        if (w_is_div) begin
            w_quick_cond = 1'b0;
            if (w_div_zero) begin
                w_quick_res = op[1] ? a : '1;
            end else begin
                w_quick_res = op[1] ? '0 : a;
            end
        end
    end

    // One radix-2 step: shift-add multiply and restoring divide share r_acc
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_mul_next, w_prod_fix;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_next, w_q_next, w_q_fix, w_r_fix, w_iter_res;

    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_ma} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};
    assign w_shift    = {r_rem, r_acc[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_ma};
    assign w_qbit     = ~w_diff[XLEN];
    assign w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_q_next   = {r_acc[XLEN-2:0], w_qbit};
    assign w_prod_fix = r_neg ? -w_mul_next : w_mul_next;
    assign w_q_fix    = r_neg ? -w_q_next : w_q_next;
    assign w_r_fix    = r_neg ? -w_rem_next : w_rem_next;

    always_comb begin
        if (r_op[2]) begin
            w_iter_res = r_op[1] ? w_r_fix : w_q_fix;
        end else if (r_op == OP_MUL) begin
            w_iter_res = w_prod_fix[XLEN-1:0];
        end else begin
            w_iter_res = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_ma    <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_neg   <= 1'b0;
            res     <= '0;
            cond    <= 1'b0;
        end else if (w_accept) begin
            r_op <= op;
            if (w_iter) begin
                r_state <= S_CALC;
                r_cnt   <= SHW'(XLEN-1);
                r_rem   <= '0;
                r_neg   <= w_neg;
                if (w_is_div) begin
                    r_ma  <= w_mb;
                    r_acc <= {{XLEN{1'b0}}, w_ma};
                end else begin
                    r_ma  <= w_ma;
                    r_acc <= {{XLEN{1'b0}}, w_mb};
                end
            end else begin
                r_state <= S_DONE;
                res     <= w_quick_res;
                cond    <= w_quick_cond;
            end
        end else begin
            case (r_state)
                S_CALC: begin
                    if (r_op[2]) begin
                        r_acc <= {r_acc[2*XLEN-1:XLEN], w_q_next};
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_mul_next;
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        res     <= w_iter_res;
                        cond    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
